execute_stage: RTL
==================

# execute_stage

Execute stage of the MyISA five-stage pipeline. It sits between the ID/EX and EX/MEM pipeline registers. It computes the ALU result from the ID/EX outputs and holds the NZCV flags register. It also runs an iterative 32-cycle multiplier, which stalls the front of the pipeline and injects bubbles downstream while it is busy.

## Interface
Parameters:
- WIDTH, 32, datapath width; only 32 is supported.
- MUL_CYCLES, 32, number of multiplier iterations; must equal WIDTH.

Ports:
- clk  in  1  pipeline clock; all state updates on the falling edge.
- reset  in  1  asynchronous, active-low reset.
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, FlagsWriteE  in  1 each  control bits from ID/EX.
- ALUControlE  in  3  operation select.
- WA3E  in  4  destination register.
- rd1E, rd2E, ExtImmE  in  32 each  operands and extended immediate.
- ALUResultM_in  out  32  result toward EX/MEM.
- WriteDataM_in  out  32  store data; always equals rd2E.
- WA3M_in  out  4  equals WA3E.
- RegWriteM_in, MemtoRegM_in, MemWriteM_in  out  1 each  gated controls.
- FlagsE  out  4  registered NZCV, {N,Z,C,V}.
- StallE  out  1  hold request to the PC, IF/ID and ID/EX registers.

## Operation
- B operand is ExtImmE when ALUSrcE=1, otherwise rd2E.
- ALUControlE encoding:
  - 000 ADD, 001 SUB (A-B)
  - 010 AND, 011 ORR, 100 EOR
  - 101 LSL by B[4:0], 110 LSR by B[4:0]
  - 111 MUL, low 32 bits of the product
- Single-cycle ops are combinational and never stall.
- Flags update only when FlagsWriteE=1 and the instruction completes; a completed MUL means the DONE cycle.
  - ADD/SUB update N, Z, C and V. C is the carry-out for ADD and NOT borrow for SUB. V is signed overflow.
  - Logic, shift and MUL update N and Z, set C=0, and leave V unchanged.
- Multiplier FSM has states IDLE, BUSY and DONE.
  - IDLE with ALUControlE=111: StallE=1 combinationally. On the next edge, load a=A, b=B, acc=0, count=0, and enter BUSY.
  - BUSY: each edge, if b[0]=1 then acc+=a. Then a<<=1, b>>=1, count++. When count reaches MUL_CYCLES-1, move to DONE. StallE=1 throughout.
  - DONE: StallE=0, ALUResultM_in=acc, controls pass through. The next edge returns the FSM to IDLE.
- While StallE=1, RegWriteM_in and MemWriteM_in are forced to 0 (bubble). Other outputs are don't-care.
- The upstream ID/EX register holds its outputs while StallE=1, so inputs stay stable for the whole MUL.

## Timing
- A single-cycle op has zero added latency: combinational from the ID/EX outputs.
- A MUL occupies the stage for 34 cycles: 1 IDLE detect, 32 BUSY, 1 DONE. StallE is high for 33 cycles.
- Back-to-back MULs: the second is detected in the IDLE cycle after DONE, with no lost cycle beyond the 34-cycle cost.
- Reset values: FSM=IDLE, acc=0, count=0, FlagsE=0000.
  - With reset-zero ID/EX inputs, StallE=0 and ALUResultM_in=0.
- Reset asserted mid-MUL aborts immediately with no flag update. After release the FSM restarts only if a MUL is present on the inputs.
- A new flag value appears on FlagsE after the falling edge that ends the completing cycle.

## Configuration
- EXEC_MUL_EN defined: the multiplier and FSM are compiled in and behave as above.
- EXEC_MUL_EN undefined: no multiplier logic.
  - ALUControlE=111 yields ALUResultM_in=0, StallE is constant 0, controls pass through ungated, and flags are not updated.

## Structure
- Package exec_pkg contains:
  - the alu_op_e enum for the 3-bit encodings;
  - the mul_state_e enum {IDLE, BUSY, DONE};
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module mul_seq holds the iterative shift-add multiplier and its FSM.
  - Ports: clk, reset, start, a, b, busy, done, product.
- execute_stage holds the ALU, operand mux, flags register and bubble gating.

## Test plan
- ADD rd1=0xFFFFFFFF, rd2=1, FlagsWrite=1 -> result 0x00000000, flags 0110 (Z, C) on the next edge.
- SUB rd1=0x80000000, ExtImm=1, ALUSrc=1 -> result 0x7FFFFFFF, flags 0011 (C, V).
- MUL rd1=7, rd2=6, RegWrite=1 -> StallE high 33 cycles with RegWriteM_in=0; DONE cycle gives result 42 (0x2A) and RegWriteM_in=1.
- MUL 0xFFFFFFFF×0xFFFFFFFF followed by MUL 3×5 -> results 0x00000001 then 0x0000000F; second completes exactly 34 cycles after the first.
- Reset pulse at BUSY count=10 -> FSM IDLE, FlagsE=0000, StallE=0 with zeroed inputs.
- EOR with FlagsWrite=0 after flags=0110 -> flags remain 0110.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types and constants for the MyISA execute stage.
// ALU opcodes, multiplier FSM states and NZCV bit positions.
package exec_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_ORR = 3'b011,
      ALU_EOR = 3'b100,
      ALU_LSL = 3'b101,
      ALU_LSR = 3'b110,
      ALU_MUL = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } mul_state_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/execute_stage_mul_seq.sv
// Iterative shift-add multiplier, one bit of b per cycle.
// Built only when EXEC_MUL_EN is defined.
module mul_seq
   import exec_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = $clog2(MUL_CYCLES);

   mul_state_e       state;
   mul_state_e       state_nx;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    count;
   logic             last;

   assign last    = (count == CW'(MUL_CYCLES - 1));
   assign product = acc;

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // busy also covers the detect cycle so the stall is combinational
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               busy     = 1'b1;
               state_nx = BUSY;
            end
         end
         BUSY: begin
            busy = 1'b1;
            if (last) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         a_q   <= '0;
         b_q   <= '0;
         acc   <= '0;
         count <= '0;
      end else if (state == IDLE && start) begin
         a_q   <= a;
         b_q   <= b;
         acc   <= '0;
         count <= '0;
      end else if (state == BUSY) begin
         if (b_q[0]) acc <= acc + a_q;
         a_q   <= a_q << 1;
         b_q   <= b_q >> 1;
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/execute_stage.sv
// MyISA execute stage: ALU, NZCV flags, bubble gating.
// Define EXEC_MUL_EN to build in the 32-cycle multiplier.
module execute_stage
   import exec_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             RegWriteE,
   input  logic             MemtoRegE,
   input  logic             MemWriteE,
   input  logic             ALUSrcE,
   input  logic             FlagsWriteE,
   input  logic [2:0]       ALUControlE,
   input  logic [3:0]       WA3E,
   input  logic [WIDTH-1:0] rd1E,
   input  logic [WIDTH-1:0] rd2E,
   input  logic [WIDTH-1:0] ExtImmE,
   output logic [WIDTH-1:0] ALUResultM_in,
   output logic [WIDTH-1:0] WriteDataM_in,
   output logic [3:0]       WA3M_in,
   output logic             RegWriteM_in,
   output logic             MemtoRegM_in,
   output logic             MemWriteM_in,
   output logic [3:0]       FlagsE,
   output logic             StallE
);

   alu_op_e          op;
   logic [WIDTH-1:0] srcb;
   logic [WIDTH-1:0] bx;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] mul_res;
   logic             mul_busy;
   logic             mul_done;
   logic             is_sub;
   logic             is_arith;
   logic             ovf;
   logic             flag_we;
   logic [3:0]       flags_nx;

   assign op       = alu_op_e'(ALUControlE);
   assign srcb     = ALUSrcE ? ExtImmE : rd2E;
   assign is_sub   = (op == ALU_SUB);
   assign is_arith = (op == ALU_ADD) || is_sub;

   // one adder: SUB is A + ~B + 1, so carry-out is NOT borrow
   assign bx  = is_sub ? ~srcb : srcb;
   assign sum = {1'b0, rd1E} + {1'b0, bx}
              + {{WIDTH{1'b0}}, is_sub};
   assign ovf = (rd1E[WIDTH-1] == bx[WIDTH-1])
             && (sum[WIDTH-1] != rd1E[WIDTH-1]);

`ifdef EXEC_MUL_EN
   mul_seq #(
      .WIDTH      (WIDTH),
      .MUL_CYCLES (MUL_CYCLES)
   ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (op == ALU_MUL),
      .a       (rd1E),
      .b       (srcb),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_res)
   );
`else
   assign mul_busy = 1'b0;
   assign mul_done = 1'b0;
   assign mul_res  = '0;
`endif

   always_comb begin
      alu_res = '0;
      unique case (op)
         ALU_ADD: alu_res = sum[WIDTH-1:0];
         ALU_SUB: alu_res = sum[WIDTH-1:0];
         ALU_AND: alu_res = rd1E & srcb;
         ALU_ORR: alu_res = rd1E | srcb;
         ALU_EOR: alu_res = rd1E ^ srcb;
         ALU_LSL: alu_res = rd1E << srcb[4:0];
         ALU_LSR: alu_res = rd1E >> srcb[4:0];
         ALU_MUL: alu_res = mul_res;
      endcase
   end

   always_comb begin
      flags_nx         = FlagsE;
      flags_nx[FLAG_N] = alu_res[WIDTH-1];
      flags_nx[FLAG_Z] = (alu_res == '0);
      flags_nx[FLAG_C] = is_arith ? sum[WIDTH] : 1'b0;
      if (is_arith) flags_nx[FLAG_V] = ovf;
   end

   // a MUL only completes in its DONE cycle
   assign flag_we = FlagsWriteE && !StallE
                 && ((op != ALU_MUL) || mul_done);

   always_ff @(negedge clk or negedge reset) begin
      if (!reset)       FlagsE <= '0;
      else if (flag_we) FlagsE <= flags_nx;
   end

   assign StallE        = mul_busy;
   assign ALUResultM_in = alu_res;
   assign WriteDataM_in = rd2E;
   assign WA3M_in       = WA3E;
   assign MemtoRegM_in  = MemtoRegE;
   assign RegWriteM_in  = RegWriteE && !StallE;
   assign MemWriteM_in  = MemWriteE && !StallE;

endmodule
